// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter: parity modes, FSM state encoding
// and the parity helper used when the parity bit is put on the line.
package uart_pkg;

    localparam logic [1:0] PAR_NONE = 2'd0;
    localparam logic [1:0] PAR_ODD  = 2'd1;
    localparam logic [1:0] PAR_EVEN = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;

    // Unused upper bits of word must be zero so they do not disturb the XOR.
    function automatic logic parity_bit(input logic [8:0] word, input logic [1:0] mode);
        logic p;
        case (mode)
            PAR_EVEN: p = ^word;
            PAR_ODD:  p = ~(^word);
            default:  p = 1'b1;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Single-clock show-ahead FIFO feeding the UART transmitter; rd_data always
// presents the oldest stored word while empty is low.
module uart_tx_fifo
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
)
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push_s, do_pop_s;

    assign full      = (count_q == CNT_FULL);
    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign rd_data   = mem_q[rd_ptr_q];
    assign do_push_s = push & ~full;
    assign do_pop_s  = pop & ~empty;

    // Pointer and occupancy update; simultaneous push and pop keep the count.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push_s) begin
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the pointers define which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: rtl/uart_tx_frame.sv
// UART frame transmitter: start, DATA_BITS LSB first, optional parity, 1-2 stops.
// Define UART_TX_FIFO_EN to add an input FIFO for back-to-back frames.
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 87,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 16
)
(
    input  logic                 i_Clock,
    input  logic                 i_Reset,
    input  logic                 i_Tx_DV,
    input  logic [DATA_BITS-1:0] i_Tx_Data,
    output logic                 o_Tx_Ready,
    output logic                 o_Tx_Active,
    output logic                 o_Tx_Serial,
    output logic                 o_Tx_Done
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W  = $clog2(DATA_BITS);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DATA_BITS - 1);
    localparam logic              STOP_LAST = 1'(STOP_BITS - 1);
    localparam logic [1:0]        PAR_MODE  = 2'(PARITY);

    if (CLKS_PER_BIT < 2) begin : g_bad_clks
        $error("uart_tx_frame: CLKS_PER_BIT must be >= 2");
    end
    if ((DATA_BITS < 5) || (DATA_BITS > 9)) begin : g_bad_data
        $error("uart_tx_frame: DATA_BITS must be 5..9");
    end
    if ((PARITY < 0) || (PARITY > 2)) begin : g_bad_par
        $error("uart_tx_frame: PARITY must be 0, 1 or 2");
    end
    if ((STOP_BITS < 1) || (STOP_BITS > 2)) begin : g_bad_stop
        $error("uart_tx_frame: STOP_BITS must be 1 or 2");
    end
    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("uart_tx_frame: FIFO_DEPTH must be a power of two >= 2");
    end

    tx_state_t              state_q, state_d;
    logic [BAUD_W-1:0]      baud_q, baud_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic                   stop_q, stop_d;
    logic [DATA_BITS-1:0]   data_q, data_d;
    logic                   serial_q, serial_d;
    logic                   active_q, active_d;
    logic                   done_q, done_d;

    logic                   avail_s;
    logic [DATA_BITS-1:0]   word_s;
    logic                   baud_end_s;
    logic                   frame_end_s;
    logic                   load_s;
    logic [IDX_W-1:0]       idx_nx_s;

    assign baud_end_s  = (baud_q == BAUD_LAST);
    assign frame_end_s = (state_q == ST_STOP) && baud_end_s && (stop_q == STOP_LAST);
    assign load_s      = avail_s && ((state_q == ST_IDLE) || frame_end_s);
    assign idx_nx_s    = idx_q + IDX_W'(1);

`ifdef UART_TX_FIFO_EN
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

    logic                 fifo_push_s;
    logic                 fifo_full_s;
    logic                 fifo_empty_s;
    logic [CNT_W-1:0]     fifo_count_s;
    logic [DATA_BITS-1:0] fifo_rdata_s;

    // Ready comes from the registered count, so a pop cannot open a slot early.
    assign o_Tx_Ready  = (fifo_count_s != CNT_FULL);
    assign fifo_push_s = i_Tx_DV & ~fifo_full_s;
    assign avail_s     = ~fifo_empty_s;
    assign word_s      = fifo_rdata_s;

    uart_tx_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (i_Clock),
        .rst     (i_Reset),
        .push    (fifo_push_s),
        .wr_data (i_Tx_Data),
        .pop     (load_s),
        .rd_data (fifo_rdata_s),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s),
        .count   (fifo_count_s)
    );
`else
    assign o_Tx_Ready = (state_q == ST_IDLE);
    assign avail_s    = i_Tx_DV & (state_q == ST_IDLE);
    assign word_s     = i_Tx_Data;
`endif

    // State and datapath registers; reset parks the line high.
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            state_q  <= ST_IDLE;
            baud_q   <= '0;
            idx_q    <= '0;
            stop_q   <= 1'b0;
            data_q   <= '0;
            serial_q <= 1'b1;
            active_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            idx_q    <= idx_d;
            stop_q   <= stop_d;
            data_q   <= data_d;
            serial_q <= serial_d;
            active_q <= active_d;
            done_q   <= done_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (avail_s) state_d = ST_START;
                else         state_d = ST_IDLE;
            end
            ST_START: begin
                if (baud_end_s) state_d = ST_DATA;
                else            state_d = ST_START;
            end
            ST_DATA: begin
                if (baud_end_s && (idx_q == IDX_LAST)) begin
                    state_d = (PAR_MODE != PAR_NONE) ? ST_PARITY : ST_STOP;
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_PARITY: begin
                if (baud_end_s) state_d = ST_STOP;
                else            state_d = ST_PARITY;
            end
            ST_STOP: begin
                if (frame_end_s) state_d = avail_s ? ST_START : ST_IDLE;
                else             state_d = ST_STOP;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Counters, shift word and line outputs; the line only moves on bit boundaries.
    always_comb begin
        baud_d   = ((state_q == ST_IDLE) || baud_end_s) ? '0 : baud_q + BAUD_W'(1);
        idx_d    = idx_q;
        stop_d   = stop_q;
        data_d   = data_q;
        serial_d = serial_q;
        active_d = active_q;
        done_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (load_s) begin
                    data_d   = word_s;
                    serial_d = 1'b0;
                    active_d = 1'b1;
                end else begin
                    serial_d = 1'b1;
                    active_d = 1'b0;
                end
            end
            ST_START: begin
                if (baud_end_s) begin
                    idx_d    = '0;
                    serial_d = data_q[0];
                end else begin
                    serial_d = 1'b0;
                end
            end
            ST_DATA: begin
                if (baud_end_s && (idx_q == IDX_LAST)) begin
                    idx_d    = '0;
                    stop_d   = 1'b0;
                    serial_d = (PAR_MODE != PAR_NONE) ? parity_bit(9'(data_q), PAR_MODE) : 1'b1;
                end else if (baud_end_s) begin
                    idx_d    = idx_nx_s;
                    serial_d = data_q[idx_nx_s];
                end else begin
                    idx_d    = idx_q;
                end
            end
            ST_PARITY: begin
                if (baud_end_s) begin
                    stop_d   = 1'b0;
                    serial_d = 1'b1;
                end else begin
                    stop_d   = stop_q;
                end
            end
            ST_STOP: begin
                if (frame_end_s) begin
                    done_d = 1'b1;
                    stop_d = 1'b0;
                    if (load_s) begin
                        data_d   = word_s;
                        serial_d = 1'b0;
                        active_d = 1'b1;
                    end else begin
                        serial_d = 1'b1;
                        active_d = 1'b0;
                    end
                end else if (baud_end_s) begin
                    stop_d = ~stop_q;
                end else begin
                    stop_d = stop_q;
                end
            end
            default: begin
                idx_d    = '0;
                stop_d   = 1'b0;
                serial_d = 1'b1;
                active_d = 1'b0;
            end
        endcase
    end

    assign o_Tx_Serial = serial_q;
    assign o_Tx_Active = active_q;
    assign o_Tx_Done   = done_q;

endmodule
